// File: rtl/cmp_table_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_table_loader_if
//  Description : Control, lookup-request and result signals of the
//                compare-table engine, grouped with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cmp_table_loader_if #(
  parameter int W = 2
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         req;
  logic         ready;
  logic         busy;
  logic         valid;
  logic         Lt;
  logic         Gt;
  logic         Eq;
  logic         err;

  // Requester side: issues start and lookups, observes results
  modport master (
    output start, a, b, req,
    input  ready, busy, valid, Lt, Gt, Eq, err
  );

  // Engine side
  modport slave (
    input  start, a, b, req,
    output ready, busy, valid, Lt, Gt, Eq, err
  );
endinterface
`default_nettype wire

// File: rtl/cmp_table_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_table_loader
//  Description : Builds a {Lt,Gt,Eq} compare table for every (a,b) pair in an
//                internal RAM, reads it back to verify it, then serves
//                one-cycle registered lookups through a req/valid handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_table_loader #(
  parameter int W = 2
) (
  input  logic               clk,
  input  logic               rst,
  cmp_table_loader_if.slave  bus
);
  localparam int AW = 2 * W;
  localparam int D  = 1 << AW;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] idx, idx_next;
  logic          err_q, err_next;
  logic          ready_q, busy_q, valid_q;
  logic [2:0]    result_q;
  logic          we;
  logic          idx_last;
  logic [2:0]    fill_data;
  logic [2:0]    rd_data;
  logic [2:0]    mem [D];

  // Entry for an address: low half is a, high half is b, unsigned compare.
  function automatic logic [2:0] entry_of(input logic [AW-1:0] addr);
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    ea = addr[W-1:0];
    eb = addr[AW-1:W];
    return {(ea < eb), (ea > eb), (ea == eb)};
  endfunction

  // The same recomputed entry feeds the FILL write and the VERIFY compare.
  assign fill_data = entry_of(idx);
  assign rd_data   = mem[idx];
  assign idx_last  = &idx;

  // Next-state logic: start overrides everything and restarts the build.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    err_next   = err_q;
    we         = 1'b0;
    if (bus.start) begin
      state_next = FILL;
      idx_next   = '0;
      err_next   = 1'b0;
    end else begin
      case (state)
        FILL: begin
          we = 1'b1;
          if (idx_last) begin
            idx_next   = '0;
            state_next = VERIFY;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
        VERIFY: begin
          if (rd_data != fill_data) err_next = 1'b1;
          // idx parks at D-1 on entering READY; it is not used there.
          if (idx_last) state_next = READY;
          else          idx_next   = idx + 1'b1;
        end
        READY: ;
        default: begin
          state_next = FILL;
          idx_next   = '0;
        end
      endcase
    end
  end

  // State, index, sticky error and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      idx     <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      err_q   <= err_next;
      ready_q <= (state_next == READY);
      busy_q  <= (state_next != READY);
    end
  end

  // Table RAM write port; contents need no reset since FILL rewrites all.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= fill_data;
  end

  // Lookup register: a request coinciding with start is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= 3'b000;
    end else if ((state == READY) && bus.req && !bus.start) begin
      valid_q  <= 1'b1;
      result_q <= mem[{bus.b, bus.a}];
    end else begin
      valid_q  <= 1'b0;
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.Lt    = result_q[2];
  assign bus.Gt    = result_q[1];
  assign bus.Eq    = result_q[0];

endmodule
`default_nettype wire
